// File: rtl/ber_sync_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ber_sync_ctrl
//  Purpose  : Bit-error-rate synchroniser. It searches for the delay D that
//             aligns the receiver decision stream with the reference PRBS9
//             stream, locks when a full window is error free, counts bits and
//             errors while locked and drops back to the search when one
//             window collects too many errors.
//  Ports    : clock, reset (async, active-high)
//             i_enable     measurement enable
//             i_valid      one-cycle strobe per baud
//             i_tx_bit     reference PRBS bit
//             i_rx_bit     receiver decision bit
//             o_delay      selected delay D (9 bits)
//             o_locked     high while locked
//             o_bit_count  bits compared while locked (saturating)
//             o_err_count  mismatches while locked (saturating)
//             o_is_zero    locked with an error count of zero
//  Revision : 1.0  initial release
// ============================================================================
module ber_sync_ctrl #(
  parameter int WINDOW    = 511,
  parameter int MAX_DELAY = 512,
  parameter int LOSS_THR  = 64,
  parameter int CW        = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_enable,
  input  logic          i_valid,
  input  logic          i_tx_bit,
  input  logic          i_rx_bit,
  output logic [8:0]    o_delay,
  output logic          o_locked,
  output logic [CW-1:0] o_bit_count,
  output logic [CW-1:0] o_err_count,
  output logic          o_is_zero
);

  localparam int HW   = MAX_DELAY - 1;
  localparam int WMAX = (WINDOW > LOSS_THR) ? WINDOW : LOSS_THR;
  localparam int WBW  = $clog2(WMAX + 1);

  localparam logic [WBW-1:0] WIN_END    = WBW'(WINDOW);
  localparam logic [WBW-1:0] LOSS_LIM   = WBW'(LOSS_THR);
  localparam logic [8:0]     DELAY_LAST = 9'(MAX_DELAY - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t         state;
  logic [HW-1:0]  hist;
  logic [WBW-1:0] win_bits;
  logic [WBW-1:0] win_errs;

  logic [HW-1:0]  hist_nx;
  logic [511:0]   taps;
  logic           expected;
  logic           mismatch;
  logic [WBW-1:0] win_bits_nx;
  logic [WBW-1:0] win_errs_nx;
  logic           win_end;
  logic           loss;
  logic [8:0]     delay_nx;
  logic [CW-1:0]  bit_cnt_nx;
  logic [CW-1:0]  err_cnt_nx;

  // Tap 0 is the current reference bit, tap k (k>0) is hist[k-1]; widening
  // to 512 lets the 9-bit delay index the taps directly.
  assign taps     = 512'({hist, i_tx_bit});
  assign hist_nx  = HW'({hist, i_tx_bit});
  assign expected = taps[o_delay];
  assign mismatch = i_valid & (i_rx_bit != expected);

  // Window counts including the current baud.
  assign win_bits_nx = win_bits + WBW'(1);
  assign win_errs_nx = win_errs + WBW'(mismatch);
  assign win_end     = (win_bits_nx == WIN_END);
  assign loss        = (win_errs_nx >= LOSS_LIM);

  assign delay_nx   = (o_delay == DELAY_LAST) ? 9'd0 : o_delay + 9'd1;
  assign bit_cnt_nx = (&o_bit_count) ? o_bit_count : o_bit_count + CW'(1);
  assign err_cnt_nx = (mismatch && !(&o_err_count)) ? o_err_count + CW'(1)
                                                    : o_err_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      hist        <= '0;
      win_bits    <= '0;
      win_errs    <= '0;
      o_delay     <= '0;
      o_locked    <= 1'b0;
      o_bit_count <= '0;
      o_err_count <= '0;
      o_is_zero   <= 1'b0;
    end else begin
      // The reference history tracks every baud, independent of state.
      if (i_valid) begin
        hist <= hist_nx;
      end

      if (!i_enable) begin
        // Disable wins over any window or loss event this cycle; the
        // locked counters and the delay keep their values.
        state     <= ST_IDLE;
        win_bits  <= '0;
        win_errs  <= '0;
        o_locked  <= 1'b0;
        o_is_zero <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            win_bits <= '0;
            win_errs <= '0;
            state    <= ST_ALIGN;
          end

          ST_ALIGN: begin
            if (i_valid) begin
              if (win_end) begin
                win_bits <= '0;
                win_errs <= '0;
                if (win_errs_nx == '0) begin
                  state       <= ST_LOCKED;
                  o_locked    <= 1'b1;
                  o_bit_count <= '0;
                  o_err_count <= '0;
                  o_is_zero   <= 1'b1;
                end else begin
                  o_delay <= delay_nx;
                end
              end else begin
                win_bits <= win_bits_nx;
                win_errs <= win_errs_nx;
              end
            end
          end

          ST_LOCKED: begin
            if (i_valid) begin
              o_bit_count <= bit_cnt_nx;
              o_err_count <= err_cnt_nx;
              if (loss) begin
                // Counters keep their totals; they clear on the next lock.
                state     <= ST_ALIGN;
                o_delay   <= delay_nx;
                o_locked  <= 1'b0;
                o_is_zero <= 1'b0;
                win_bits  <= '0;
                win_errs  <= '0;
              end else begin
                o_is_zero <= (err_cnt_nx == '0);
                if (win_end) begin
                  win_bits <= '0;
                  win_errs <= '0;
                end else begin
                  win_bits <= win_bits_nx;
                  win_errs <= win_errs_nx;
                end
              end
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ber_sync_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ber_sync_ctrl
//  Purpose  : Self-checking bench for ber_sync_ctrl. Two instances: one with
//             default parameters, one with a short window and narrow counters
//             so delay wrap and counter saturation are reachable quickly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ber_sync_ctrl;

  localparam int W1 = 511, T1 = 64;
  localparam int W2 = 16,  T2 = 8;
  localparam int MD = 512;
  localparam logic [63:0] CMAX1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CMAX2 = 64'h0000_0000_0000_00FF;

  localparam int M_IDLE = 0, M_ALIGN = 1, M_LOCKED = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en1 = 1'b0, en2 = 1'b0, valid = 1'b0, tx = 1'b0, rx = 1'b0;

  logic [8:0]  d1, d2;
  logic        l1, l2, z1, z2;
  logic [63:0] bc1, ec1;
  logic [7:0]  bc2, ec2;

  always #5 clock = ~clock;

  ber_sync_ctrl dut1 (
    .clock(clock), .reset(reset), .i_enable(en1), .i_valid(valid),
    .i_tx_bit(tx), .i_rx_bit(rx), .o_delay(d1), .o_locked(l1),
    .o_bit_count(bc1), .o_err_count(ec1), .o_is_zero(z1)
  );

  ber_sync_ctrl #(.WINDOW(W2), .MAX_DELAY(MD), .LOSS_THR(T2), .CW(8)) dut2 (
    .clock(clock), .reset(reset), .i_enable(en2), .i_valid(valid),
    .i_tx_bit(tx), .i_rx_bit(rx), .o_delay(d2), .o_locked(l2),
    .o_bit_count(bc2), .o_err_count(ec2), .o_is_zero(z2)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int          st;
    int          d;
    int          wb;
    int          we;
    logic [63:0] bc;
    logic [63:0] ec;
    bit          lock;
    bit          zero;
  } mdl_t;

  mdl_t        m1, m2;
  logic [511:0] mpast;   // bit k = reference bit k+1 valids ago

  function automatic mdl_t mzero();
    mdl_t n;
    n.st = M_IDLE; n.d = 0; n.wb = 0; n.we = 0;
    n.bc = 0; n.ec = 0; n.lock = 0; n.zero = 0;
    return n;
  endfunction

  function automatic bit mexp(input int d, input bit t);
    return (d == 0) ? t : mpast[d-1];
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int win, input int thr,
                                 input logic [63:0] cmax, input bit en,
                                 input bit v, input bit mm);
    mdl_t n = m;
    if (!en) begin
      n.st = M_IDLE; n.wb = 0; n.we = 0; n.lock = 0; n.zero = 0;
      return n;
    end
    case (m.st)
      M_IDLE: n.st = M_ALIGN;
      M_ALIGN: if (v) begin
        n.wb = m.wb + 1;
        n.we = m.we + int'(mm);
        if (n.wb == win) begin
          if (n.we == 0) begin
            n.st = M_LOCKED; n.bc = 0; n.ec = 0; n.lock = 1; n.zero = 1;
          end else begin
            n.d = (m.d + 1) % MD;
          end
          n.wb = 0; n.we = 0;
        end
      end
      M_LOCKED: if (v) begin
        if (m.bc != cmax) n.bc = m.bc + 1;
        if (mm && m.ec != cmax) n.ec = m.ec + 1;
        n.wb = m.wb + 1;
        n.we = m.we + int'(mm);
        n.zero = (n.ec == 0);
        if (n.we >= thr) begin
          n.st = M_ALIGN; n.d = (m.d + 1) % MD;
          n.wb = 0; n.we = 0; n.lock = 0; n.zero = 0;
        end else if (n.wb == win) begin
          n.wb = 0; n.we = 0;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m1    <= mzero();
      m2    <= mzero();
      mpast <= '0;
    end else begin
      m1 <= mstep(m1, W1, T1, CMAX1, en1, valid, valid && (rx != mexp(m1.d, tx)));
      m2 <= mstep(m2, W2, T2, CMAX2, en2, valid, valid && (rx != mexp(m2.d, tx)));
      if (valid) mpast <= {mpast[510:0], tx};
    end
  end

  task automatic cmp(input string nm, input logic [8:0] d, input logic l,
                     input logic [63:0] bc, input logic [63:0] ec,
                     input logic z, input mdl_t m);
    n_chk++;
    if (d !== 9'(m.d) || l !== m.lock || bc !== m.bc || ec !== m.ec || z !== m.zero) begin
      n_fail++;
      $display("FAIL %s t=%0t: got d=%0d l=%0b bc=%0d ec=%0d z=%0b expected d=%0d l=%0b bc=%0d ec=%0d z=%0b",
               nm, $time, d, l, bc, ec, z, m.d, m.lock, m.bc, m.ec, m.zero);
    end
  endtask

  // Single compare process, on the inactive edge.
  always @(negedge clock) begin
    if (!reset) begin
      cmp("model_dut1", d1, l1, bc1, ec1, z1, m1);
      cmp("model_dut2", d2, l2, 64'(bc2), 64'(ec2), z2, m2);
    end
  end

  // ---------------- stimulus ----------------
  logic [8:0]    lfsr;
  logic [1023:0] sreg;   // bench copy of past reference bits

  // k >= 0: rx is tx delayed k valids; k = -1: rx opposes dut2's expected
  // bit; k = -2: rx random. Called at a falling edge, returns at the next.
  task automatic cyc(input bit v, input int k, input bit flip);
    bit t;
    bit r;
    if (v) begin
      t = lfsr[8] ^ lfsr[4];
      lfsr = {lfsr[7:0], t};
    end else begin
      t = 1'($urandom_range(0, 1));
    end
    if (k == -1)      r = ~mexp(m2.d, t);
    else if (k == -2) r = 1'($urandom_range(0, 1));
    else if (k == 0)  r = t;
    else              r = sreg[k-1];
    tx    = t;
    valid = v;
    rx    = r ^ flip;
    if (v) sreg = {sreg[1022:0], t};
    @(negedge clock);
  endtask

  // One valid baud, sometimes preceded by an idle gap.
  task automatic vcyc(input int k, input bit flip);
    if ($urandom_range(0, 7) == 0) cyc(1'b0, k, 1'b0);
    cyc(1'b1, k, flip);
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    cyc(1'b0, 0, 1'b0);
    reset = 1'b0;
  endtask

  int n;
  int ktab[4] = '{0, 2, 5, -2};

  initial begin
    lfsr = 9'($urandom_range(1, 511));
    sreg = '0;
    repeat (3) @(negedge clock);

    // Reset values.
    check("rst_delay", 64'(d1), 0);
    check("rst_locked", 64'(l1), 0);
    check("rst_bits", bc1, 0);
    check("rst_errs", ec1, 0);
    check("rst_zero", 64'(z1), 0);
    reset = 1'b0;

    // Delay 0: lock after exactly one window, then count 1000 bits.
    en1 = 1'b1;
    cyc(1'b0, 0, 1'b0);
    n = 0;
    while (!l1 && n < 600) begin vcyc(0, 1'b0); n++; end
    check("lock_d0_valids", 64'(n), 511);
    check("lock_d0_delay", 64'(d1), 0);
    check("lock_d0_bits", bc1, 0);
    for (int i = 0; i < 1000; i++) vcyc(0, 1'b0);
    check("d0_bits_1000", bc1, 1000);
    check("d0_errs", ec1, 0);
    check("d0_zero", 64'(z1), 1);

    // Delay 37.
    rst_pulse();
    cyc(1'b0, 0, 1'b0);
    n = 0;
    while (!l1 && n < 40 * 511) begin vcyc(37, 1'b0); n++; end
    check("lock_d37_locked", 64'(l1), 1);
    check("lock_d37_delay", 64'(d1), 37);
    for (int i = 0; i < 200; i++) vcyc(37, 1'b0);
    check("d37_errs", ec1, 0);
    check("d37_zero", 64'(z1), 1);

    // Delay 5, three isolated flips.
    rst_pulse();
    cyc(1'b0, 0, 1'b0);
    n = 0;
    while (!l1 && n < 7 * 511) begin vcyc(5, 1'b0); n++; end
    check("lock_d5_delay", 64'(d1), 5);
    for (int i = 0; i < 60; i++) vcyc(5, (i % 20) == 10);
    check("flip_errs", ec1, 3);
    check("flip_zero", 64'(z1), 0);
    check("flip_locked", 64'(l1), 1);

    // Move rx to delay 6: lock is lost, search resumes at 6 and relocks.
    n = 0;
    while (l1 && n < 2 * 511) begin vcyc(6, 1'b0); n++; end
    check("loss_locked", 64'(l1), 0);
    check("loss_delay", 64'(d1), 6);
    n = 0;
    while (!l1 && n < 600) begin vcyc(6, 1'b0); n++; end
    check("relock_valids", 64'(n), 511);
    check("relock_delay", 64'(d1), 6);
    check("relock_bits", bc1, 0);
    check("relock_errs", ec1, 0);
    for (int i = 0; i < 50; i++) vcyc(6, 1'b0);
    check("relock_bits_50", bc1, 50);

    // Drop enable: unlocked next clock, counters held, that baud not counted.
    en1 = 1'b0;
    cyc(1'b1, 6, 1'b0);
    check("dis_locked", 64'(l1), 0);
    check("dis_bits", bc1, 50);
    check("dis_delay", 64'(d1), 6);
    reset = 1'b1;
    cyc(1'b0, 0, 1'b0);
    check("rst2_delay", 64'(d1), 0);
    check("rst2_bits", bc1, 0);
    check("rst2_locked", 64'(l1), 0);
    reset = 1'b0;

    // Short-window instance: walk D to 511, then wrap and lock at 2.
    en2 = 1'b1;
    cyc(1'b0, 0, 1'b0);
    n = 0;
    while (m2.d != 511 && n < 600 * W2) begin vcyc(-1, 1'b0); n++; end
    check("walk_delay", 64'(d2), 511);
    n = 0;
    while (!l2 && n < 10 * W2) begin vcyc(2, 1'b0); n++; end
    check("wrap_locked", 64'(l2), 1);
    check("wrap_delay", 64'(d2), 2);

    // Seven errors per window stays locked; both 8-bit counters saturate.
    for (int i = 0; i < 40 * W2; i++) vcyc(2, (i % W2) < 7);
    check("sat_bits", 64'(bc2), 255);
    check("sat_errs", 64'(ec2), 255);
    check("sat_locked", 64'(l2), 1);
    // Eight errors in one window loses lock.
    for (int i = 0; i < 8; i++) vcyc(2, 1'b1);
    check("thr_locked", 64'(l2), 0);
    check("thr_delay", 64'(d2), 3);
    check("thr_bits_held", 64'(bc2), 255);

    // Random traffic with enable toggles and asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      en1 = ($urandom_range(0, 99) != 0);
      en2 = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end else begin
        cyc($urandom_range(0, 3) != 0, ktab[$urandom_range(0, 3)],
            $urandom_range(0, 31) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ber_sync_ctrl.md
BER_SYNC_CTRL -- requirements
Module: ber_sync_ctrl

Interface
REQ-001 Parameter WINDOW, default 511: received bits per alignment trial and per loss-of-lock check window.
REQ-002 Parameter MAX_DELAY, default 512: number of candidate delays, 0..MAX_DELAY-1.
REQ-003 Parameter LOSS_THR, default 64: errors in one locked window that force re-alignment.
REQ-004 Parameter CW, default 64: width of bit and error counters.
REQ-005 clock  input  1  system clock.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 i_enable  input  1  measurement enable (RX enable switch).
REQ-008 i_valid  input  1  one-cycle strobe per baud; all other inputs are ignored while i_valid=0.
REQ-009 i_tx_bit  input  1  reference PRBS9 bit for this baud.
REQ-010 i_rx_bit  input  1  receiver decision bit for this baud.
REQ-011 o_delay  output  9  currently selected delay D.
REQ-012 o_locked  output  1  high only in state LOCKED.
REQ-013 o_bit_count  output  CW  bits compared while locked.
REQ-014 o_err_count  output  CW  mismatches while locked.
REQ-015 o_is_zero  output  1  o_locked AND o_err_count==0 (drives BER=0 LED).

Function
REQ-016 History register: MAX_DELAY-1 bits; on each i_valid it shifts in i_tx_bit, hist[0] holding the previous baud's bit.
REQ-017 Expected bit for delay D: i_tx_bit when D=0; otherwise hist[D-1], sampled before that cycle's shift.
REQ-018 Mismatch = i_valid AND (i_rx_bit != expected bit); no comparison takes place without i_valid.
REQ-019 States: IDLE, ALIGN, LOCKED; all outputs registered, updating on the clock edge after the triggering i_valid.
REQ-020 IDLE: window bit/error counters held at 0; o_delay and the CW counters hold their values; i_enable=1 -> ALIGN on the next clock.
REQ-021 ALIGN: each i_valid increments the window bit counter and, on a mismatch, the window error counter.
REQ-022 ALIGN window end (window bit counter reaches WINDOW, including that baud): window errors == 0 -> LOCKED; otherwise D <= D+1, wrapping MAX_DELAY-1 -> 0; window counters cleared in both cases.
REQ-023 Entry into LOCKED clears o_bit_count and o_err_count to 0 in the same edge.
REQ-024 LOCKED: each i_valid increments o_bit_count; each mismatch increments o_err_count; both saturate at all ones and never wrap.
REQ-025 LOCKED loss check: window counters keep running. If window errors reach LOSS_THR before window end -> ALIGN with D <= D+1 (wrapping), window counters cleared. At window end with fewer errors, window counters clear and the state stays LOCKED.
REQ-026 The CW counters hold their values on loss of lock and are cleared only at the next lock entry.
REQ-027 i_enable=0 in any state -> IDLE on the next clock, with priority over window-end and loss events in the same cycle; an i_valid in that cycle is not counted.
REQ-028 o_delay width is fixed at 9 bits; MAX_DELAY > 512 is illegal.

Reset
REQ-029 Reset (asynchronous) forces: state IDLE, D=0, history all 0, window counters 0, o_bit_count=0, o_err_count=0, o_locked=0, o_is_zero=0.
REQ-030 Reset asserted mid-ALIGN or mid-LOCKED aborts immediately with no partial update; after release the block resumes from IDLE.

Verification
REQ-031 rx = tx delayed 37 valids, i_enable=1 -> o_locked rises after the D=37 window; o_delay=37; o_err_count stays 0; o_is_zero=1.
REQ-032 rx = tx delayed 0 -> lock at D=0 after exactly 511 valids; o_bit_count=0 at lock, 1000 after a further 1000 valids.
REQ-033 Locked at D=5, then 3 isolated rx bit flips -> o_err_count=3, o_is_zero=0, o_locked remains 1.
REQ-034 Locked, then rx delay changed to 6 (about 50% errors) -> o_locked falls within 128 valids; the state returns to ALIGN from D=6, relocks at D=6, and the counters clear on relock.
REQ-035 Locked, drop i_enable -> o_locked=0 next clock with counters held; reassert reset -> all outputs 0.
REQ-036 Lock at D=511 and the wrap case: rx delayed 2 with search starting at D=511 -> D wraps to 0 and lock occurs at D=2.
